// File: rtl/image_fetch_sequencer_pkg.sv
// rtl/image_fetch_sequencer_pkg.sv - shared constants, state encoding and base-address helper
// Purpose: sizing constants for the stored image set, FSM state type, and the
//          image-index to base-address mapping used by the fetch sequencer,
//          the inference controller and the image memory.
package image_fetch_sequencer_pkg;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 32;
  localparam int IMG_SIZE   = 784;
  localparam int NUM_IMAGES = 5;
  localparam int IDX_W      = 3;
  // Pixel counter must be able to hold IMG_SIZE itself ("all words fetched").
  localparam int CNT_W      = $clog2(IMG_SIZE + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Images are stored back to back from address 0.
  function automatic logic [ADDR_W-1:0] image_base(input logic [IDX_W-1:0] idx);
    return ADDR_W'(idx) * ADDR_W'(IMG_SIZE);
  endfunction

endpackage

// File: rtl/image_fetch_sequencer_if.sv
// rtl/image_fetch_sequencer_if.sv - image memory read bus plus pixel stream handshake
// Purpose: bundles the memory address/data pair and the valid/ready pixel stream.
// Signals: mem_addr (to memory), mem_data (combinational read data),
//          out_data/out_valid/out_last (pixel beat), out_ready (downstream accept).
// Modports: master = fetch sequencer, slave = memory + downstream stage.
interface image_fetch_sequencer_if;
  import image_fetch_sequencer_pkg::*;

  logic        [ADDR_W-1:0] mem_addr;
  logic signed [DATA_W-1:0] mem_data;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;

  modport master (
    output mem_addr,
    input  mem_data,
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  mem_addr,
    output mem_data,
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/image_fetch_sequencer_addr_gen.sv
// rtl/image_fetch_sequencer_addr_gen.sv - image base computation and address/count stepping
// Purpose: holds the registered memory address and the per-frame pixel count.
// Ports: clk, reset (sync, active-high); load + idx start a frame at the image
//        base; advance steps address and count by one; addr, count are the
//        registers; is_last flags the final pixel index, all_fetched flags
//        that every pixel of the frame has been read.
module image_addr_gen
  import image_fetch_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [IDX_W-1:0]  idx,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic [CNT_W-1:0]  count,
  output logic              is_last,
  output logic              all_fetched
);

  always_ff @(posedge clk) begin
    if (reset) begin
      addr  <= '0;
      count <= '0;
    end else if (load) begin
      addr  <= image_base(idx);
      count <= '0;
    end else if (advance) begin
      addr  <= addr + ADDR_W'(1);
      count <= count + CNT_W'(1);
    end
  end

  assign is_last     = (count == CNT_W'(IMG_SIZE - 1));
  assign all_fetched = (count == CNT_W'(IMG_SIZE));

endmodule

// File: rtl/image_fetch_sequencer.sv
// rtl/image_fetch_sequencer.sv - streams one stored image from memory to the datapath
// Purpose: on start, reads IMG_SIZE words of image img_idx and presents them as
//          a valid/ready pixel stream, flagging the final pixel and pulsing done.
// Ports: clk, reset (sync, active-high); start/img_idx request a frame (IDLE only);
//        abort drops the current frame; bus is the memory + stream interface;
//        busy = not IDLE; done = one-cycle pulse after last beat; err = one-cycle
//        pulse on start with an out-of-range index.
module image_fetch_sequencer
  import image_fetch_sequencer_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [IDX_W-1:0]            img_idx,
  input  logic                        abort,
  image_fetch_sequencer_if.master     bus,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  state_t                   state;
  logic signed [DATA_W-1:0] out_data_q;
  logic                     out_valid_q;
  logic                     out_last_q;

  logic [CNT_W-1:0]         count;
  logic                     is_last;
  logic                     all_fetched;
  logic                     idx_ok;
  logic                     slot_free;
  logic                     last_accepted;
  logic                     load;
  logic                     fetch;

  assign idx_ok        = (int'(img_idx) < NUM_IMAGES);
  // The output register can take a new word if empty or being drained this cycle.
  assign slot_free     = !out_valid_q || bus.out_ready;
  assign last_accepted = out_valid_q && bus.out_ready && out_last_q;
  assign load          = (state == IDLE) && start && idx_ok;
  assign fetch         = (state == STREAM) && !abort && slot_free && !all_fetched;

  image_addr_gen u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .idx         (img_idx),
    .advance     (fetch),
    .addr        (bus.mem_addr),
    .count       (count),
    .is_last     (is_last),
    .all_fetched (all_fetched)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (idx_ok) begin
              state <= STREAM;
              busy  <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (abort) begin
            state       <= IDLE;
            busy        <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end else if (last_accepted) begin
            state       <= FINISH;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done        <= 1'b1;
          end else if (slot_free) begin
            if (!all_fetched) begin
              out_data_q  <= bus.mem_data;
              out_valid_q <= 1'b1;
              out_last_q  <= is_last;
            end else begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;

endmodule
